ahb_bus_arbiter: RTL

// Two-master AHB-style bus arbiter for the shared system bus. Grants one master per

---
 rtl/ahb_bus_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter -- two-master AHB-style bus arbiter.
// Grants one master per transfer, publishes the address-phase owner (HMASTER)
// and the data-phase owner one transfer later (SEL, the write-data mux select).
// A per-owner beat cap (MAX_BEATS) forces handover when the other master waits.
// Optional feature macro: ARB_LOCK_EN adds HLOCK_1/HLOCK_2 inputs and the
// HMASTLOCK output; a locked owner keeps the bus until it drops its request.
module ahb_bus_arbiter #(
  parameter int PRIORITY_MODE = 0,  // 0 round-robin, 1 master 1 wins every contest
  parameter int MAX_BEATS     = 8   // beats per tenure before forced handover, >= 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       HBUSREQ_1,
  input  logic       HBUSREQ_2,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
`ifdef ARB_LOCK_EN
  input  logic       HLOCK_1,
  input  logic       HLOCK_2,
  output logic       HMASTLOCK,
`endif
  output logic       HGRANT_1,
  output logic       HGRANT_2,
  output logic [1:0] HMASTER,
  output logic [1:0] SEL
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS - 1);

  // State encoding equals the one-hot HMASTER encoding, so HMASTER is the state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_M1   = 2'b01,
    ST_M2   = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic             last_m2, last_nxt;  // 1: most recent owner was master 2
  logic [1:0]       sel_p1;             // data-phase owner, one transfer behind state

  logic   own_req;
  logic   oth_req;
  state_t oth_st;
  logic   beat;
  logic   own_lock;

  // Counter saturates at the cap so a lone owner can keep streaming indefinitely.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_MAX)
      sat_inc = cnt;
    else
      sat_inc = cnt + 1'b1;
  endfunction

  // Only NONSEQ/SEQ transfers consume the owner's beat budget.
  assign beat = (HTRANS == 2'b10) || (HTRANS == 2'b11);

  // Request of the current owner, request of the other master, and its state.
  always_comb begin
    own_req = 1'b0;
    oth_req = 1'b0;
    oth_st  = ST_IDLE;
    case (state)
      ST_M1: begin
        own_req = HBUSREQ_1;
        oth_req = HBUSREQ_2;
        oth_st  = ST_M2;
      end
      ST_M2: begin
        own_req = HBUSREQ_2;
        oth_req = HBUSREQ_1;
        oth_st  = ST_M1;
      end
      default: begin
        own_req = 1'b0;
        oth_req = 1'b0;
        oth_st  = ST_IDLE;
      end
    endcase
  end

`ifdef ARB_LOCK_EN
  assign own_lock = (state == ST_M1) ? HLOCK_1 :
                    (state == ST_M2) ? HLOCK_2 : 1'b0;
`else
  assign own_lock = 1'b0;
`endif

  // Next-state, beat counter and last-owner bookkeeping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    last_nxt  = last_m2;
    case (state)
      ST_IDLE: begin
        if (HBUSREQ_1 && HBUSREQ_2)
          state_nxt = ((PRIORITY_MODE != 0) || last_m2) ? ST_M1 : ST_M2;
        else if (HBUSREQ_1)
          state_nxt = ST_M1;
        else if (HBUSREQ_2)
          state_nxt = ST_M2;
      end
      ST_M1, ST_M2: begin
        if (!own_req)
          state_nxt = oth_req ? oth_st : ST_IDLE;
        else if (beat) begin
          // A locked owner ignores the cap; the counter still saturates so the
          // cap takes effect on the first beat after the lock is released.
          if (!own_lock && oth_req && (beat_cnt == CNT_MAX))
            state_nxt = oth_st;
          else
            cnt_nxt = sat_inc(beat_cnt);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (state_nxt != state) begin
      cnt_nxt = '0;
      if (state_nxt == ST_M1)
        last_nxt = 1'b0;
      else if (state_nxt == ST_M2)
        last_nxt = 1'b1;
    end
  end

  // Arbitration state; every update waits for HREADY so wait states freeze it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      last_m2  <= 1'b1;
    end else if (HREADY) begin
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
      last_m2  <= last_nxt;
    end
  end

  // ---- data-phase stage: SEL lags HMASTER by one completed transfer ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      sel_p1 <= 2'b00;
    else if (HREADY)
      sel_p1 <= state;
  end

`ifdef ARB_LOCK_EN
  // Lock indication tracks the owner's HLOCK; no owner means no lock.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      HMASTLOCK <= 1'b0;
    else if (HREADY)
      HMASTLOCK <= own_lock;
  end
`endif

  assign HGRANT_1 = (state == ST_M1);
  assign HGRANT_2 = (state == ST_M2);
  assign HMASTER  = state;
  assign SEL      = sel_p1;

endmodule
